// File: rtl/hs_rx_responder_if.sv
// Bundles the remote req/ack/data signals and the local valid/ready consumer side of hs_rx_responder.
// HS_RX_PARITY_EN adds par_async/par_err to both modports.
interface hs_rx_responder_if #(
    parameter int WIDTH = 8
);
    logic             req_async;
    logic [WIDTH-1:0] data_async;
    logic             ack;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             rx_idle;
`ifdef HS_RX_PARITY_EN
    logic             par_async;
    logic             par_err;

    modport slave (
        input  req_async, data_async, par_async, out_ready,
        output ack, out_valid, out_data, rx_idle, par_err
    );
    modport master (
        output req_async, data_async, par_async, out_ready,
        input  ack, out_valid, out_data, rx_idle, par_err
    );
`else
    modport slave (
        input  req_async, data_async, out_ready,
        output ack, out_valid, out_data, rx_idle
    );
    modport master (
        output req_async, data_async, out_ready,
        input  ack, out_valid, out_data, rx_idle
    );
`endif
endinterface

// File: rtl/hs_rx_responder.sv
// Receive side of a 4-phase req/ack clock-domain crossing: synchronizes req, captures data, buffers in a FIFO.
// Optional even-parity checking of the captured word is enabled by defining HS_RX_PARITY_EN.
module hs_rx_responder #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                sclk,
    input  logic                rst_n,
    hs_rx_responder_if.slave    rx
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_WAIT_REQ_LOW
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic               w_req_s;
    logic               r_ack;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [AW-1:0]      r_wptr;
    logic [AW-1:0]      r_rptr;
    logic [AW-1:0]      w_rptr_next;
    logic [CW-1:0]      r_count;
    logic [CW-1:0]      w_count_next;
    logic [CW-1:0]      w_head_count;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_data;
    logic               r_rx_idle;

    // Only the first stage ever sees req_async.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx.req_async};
        end
    end

    assign w_req_s = r_sync[SYNC_STAGES-1];
    assign w_full  = (r_count == FULL_CNT);
    assign w_pop   = r_out_valid && rx.out_ready;

    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req_s && !w_full) begin
                    w_state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                w_push       = 1'b1;
                w_state_next = ST_WAIT_REQ_LOW;
            end
            ST_WAIT_REQ_LOW: begin
                if (!w_req_s) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);
    assign w_rptr_next  = w_pop ? r_rptr + AW'(1) : r_rptr;
    // Words pushed this cycle are excluded so out_valid trails the write by one cycle.
    assign w_head_count = r_count - CW'(w_pop);

    always_ff @(posedge sclk) begin
        if (w_push) begin
            r_mem[r_wptr] <= rx.data_async;
        end
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ack       <= 1'b0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_rx_idle   <= 1'b1;
        end else begin
            r_state     <= w_state_next;
            r_ack       <= (w_state_next == ST_WAIT_REQ_LOW);
            r_wptr      <= w_push ? r_wptr + AW'(1) : r_wptr;
            r_rptr      <= w_rptr_next;
            r_count     <= w_count_next;
            r_out_valid <= (w_head_count != '0);
            r_out_data  <= (w_head_count != '0) ? r_mem[w_rptr_next] : '0;
            r_rx_idle   <= (w_state_next == ST_IDLE) && (w_count_next == '0);
        end
    end

    assign rx.ack       = r_ack;
    assign rx.out_valid = r_out_valid;
    assign rx.out_data  = r_out_data;
    assign rx.rx_idle   = r_rx_idle;

`ifdef HS_RX_PARITY_EN
    logic r_par_err;

    // Sticky: a bad word is still stored and acknowledged, only reset clears the flag.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_par_err <= 1'b0;
        end else if (w_push && ((^rx.data_async) != rx.par_async)) begin
            r_par_err <= 1'b1;
        end
    end

    assign rx.par_err = r_par_err;
`endif

endmodule

// File: tb/tb_hs_rx_responder.sv
// Scoreboard bench for hs_rx_responder: directed remote transfers, monitor compares delivered words in order.
// Parity cases run only when HS_RX_PARITY_EN is defined.
module tb_hs_rx_responder;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;

    logic sclk = 1'b0;
    logic rst_n = 1'b0;
    always #5 sclk = ~sclk;

    hs_rx_responder_if #(.WIDTH(WIDTH)) bus ();

    hs_rx_responder #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .SYNC_STAGES(SYNC)
    ) dut (
        .sclk (sclk),
        .rst_n(rst_n),
        .rx   (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_q[$];
    logic       stall_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge sclk);
        #1;
    endtask

    task automatic wait_ack(input logic lvl, input int budget, input string name);
        int e;
        e = 0;
        while (bus.ack !== lvl && e < budget) begin
            tick();
            e++;
        end
        check(name, {31'b0, bus.ack}, {31'b0, lvl});
    endtask

    task automatic set_par(input logic p);
`ifdef HS_RX_PARITY_EN
        bus.par_async = p;
`else
        if (p) $display("note: parity bit ignored in this build");
`endif
    endtask

    task automatic send_word(input logic [7:0] d, input logic p);
        bus.data_async = d;
        set_par(p);
        bus.req_async  = 1'b1;
        exp_q.push_back(d);
        wait_ack(1'b1, 40, "ack_rise");
        bus.req_async = 1'b0;
        wait_ack(1'b0, 40, "ack_fall");
        tick();
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        bus.out_ready = 1'b1;
        while (exp_q.size() != 0 && t < 60) begin
            tick();
            t++;
        end
        tick();
        bus.out_ready = 1'b0;
        check(name, exp_q.size(), 0);
    endtask

    // Monitor: pops the scoreboard on every accepted word and checks head stability under stall.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic [7:0] mon_exp;
    initial forever begin
        @(negedge sclk);
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", {31'b0, bus.out_valid}, 32'd1);
                check("stall_data", {24'b0, bus.out_data}, {24'b0, prev_data});
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_word: got %02h expected none", bus.out_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("word", {24'b0, bus.out_data}, {24'b0, mon_exp});
                    $display("rx word %02h (expected %02h)", bus.out_data, mon_exp);
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
        end
    end

    initial begin
        int t;
        bus.req_async  = 1'b0;
        bus.data_async = 8'h00;
        bus.out_ready  = 1'b0;
        set_par(1'b0);

        // Reset state
        tick(2);
        check("rst_ack", {31'b0, bus.ack}, 32'd0);
        check("rst_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_data", {24'b0, bus.out_data}, 32'd0);
        check("rst_idle", {31'b0, bus.rx_idle}, 32'd1);
`ifdef HS_RX_PARITY_EN
        check("rst_par_err", {31'b0, bus.par_err}, 32'd0);
`endif
        rst_n = 1'b1;
        tick();

        // Single transfer with latency checks
        bus.data_async = 8'hA5;
        bus.req_async  = 1'b1;
        exp_q.push_back(8'hA5);
        tick(3);
        check("ack_early", {31'b0, bus.ack}, 32'd0);
        tick();
        check("ack_lat", {31'b0, bus.ack}, 32'd1);
        check("valid_early", {31'b0, bus.out_valid}, 32'd0);
        tick();
        check("valid_lat", {31'b0, bus.out_valid}, 32'd1);
        check("data_lat", {24'b0, bus.out_data}, 32'hA5);
        bus.req_async = 1'b0;
        wait_ack(1'b0, 3, "ack_fall_3");
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("idle_after_pop", {31'b0, bus.rx_idle}, 32'd1);
        check("valid_after_pop", {31'b0, bus.out_valid}, 32'd0);
        check("data_zero_empty", {24'b0, bus.out_data}, 32'd0);
        check("q_single", exp_q.size(), 0);
        tick(2);

        // Burst into full FIFO, fifth request must wait
        for (int i = 1; i <= 4; i++) send_word(8'(i), 1'b0);
        check("full_head_valid", {31'b0, bus.out_valid}, 32'd1);
        check("full_head_data", {24'b0, bus.out_data}, 32'h01);
        bus.data_async = 8'h05;
        bus.req_async  = 1'b1;
        exp_q.push_back(8'h05);
        tick(10);
        check("full_noack", {31'b0, bus.ack}, 32'd0);
        check("full_not_idle", {31'b0, bus.rx_idle}, 32'd0);
        bus.out_ready = 1'b1;
        wait_ack(1'b1, 40, "ack_after_drain");
        bus.req_async = 1'b0;
        wait_ack(1'b0, 40, "ack_fall_5");
        drain("drain_burst");
        tick(2);

        // Consumer toggling ready during a stream
        stall_on = 1'b1;
        fork
            begin
                while (stall_on) begin
                    bus.out_ready = ~bus.out_ready;
                    tick();
                end
            end
        join_none
        send_word(8'h10, 1'b0);
        send_word(8'h20, 1'b0);
        send_word(8'h30, 1'b0);
        t = 0;
        while (exp_q.size() != 0 && t < 60) begin
            tick();
            t++;
        end
        stall_on = 1'b0;
        bus.out_ready = 1'b0;
        check("drain_stall", exp_q.size(), 0);
        tick(3);

        // Reset while in WAIT_REQ_LOW with two words buffered
        send_word(8'h41, 1'b0);
        send_word(8'h42, 1'b0);
        bus.data_async = 8'h43;
        bus.req_async  = 1'b1;
        wait_ack(1'b1, 40, "ack_pre_reset");
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_ack", {31'b0, bus.ack}, 32'd0);
        check("mid_rst_valid", {31'b0, bus.out_valid}, 32'd0);
        check("mid_rst_idle", {31'b0, bus.rx_idle}, 32'd1);
        bus.data_async = 8'h77;
        tick(2);
        rst_n = 1'b1;
        exp_q.push_back(8'h77);
        wait_ack(1'b1, 20, "ack_after_reset");
        bus.req_async = 1'b0;
        wait_ack(1'b0, 20, "ack_fall_after_reset");
        drain("drain_reset");

`ifdef HS_RX_PARITY_EN
        // Parity error is sticky and the word still gets through
        send_word(8'h03, 1'b1);
        check("par_err_set", {31'b0, bus.par_err}, 32'd1);
        drain("drain_par_bad");
        send_word(8'h07, 1'b1);
        check("par_err_sticky", {31'b0, bus.par_err}, 32'd1);
        drain("drain_par_good");
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("par_err_clear", {31'b0, bus.par_err}, 32'd0);
`endif

        tick(2);
        check("end_idle", {31'b0, bus.rx_idle}, 32'd1);
        check("end_queue", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end
endmodule
